// File: rtl/sample_msg_combiner.sv
// sample_msg_combiner
//   Merges a sample stream and a message stream onto one nd-qualified word bus.
//   A message (header word with MSB=1 carrying a length, then that many content
//   words with MSB=0) is always emitted contiguously; samples fill the gaps.
//   Message words are staged in a FIFO and only become visible to the output
//   side once the whole message has arrived (committed), so a broken message
//   can be thrown away without ever reaching the output.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   in_samples     in   sample word, valid when in_samples_nd
//   in_samples_nd  in   sample strobe
//   in_msg         in   message word (header or content), valid when in_msg_nd
//   in_msg_nd      in   message strobe
//   out_data       out  merged stream word (registered)
//   out_nd         out  out_data valid, one cycle per word (registered)
//   error          out  sticky error flag, cleared only by rst
module sample_msg_combiner #(
    parameter int WIDTH            = 32,
    parameter int SAMPLE_BUF_LOG   = 4,
    parameter int MSG_BUF_LOG      = 6,
    parameter int MSG_LENGTH_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_samples,
    input  logic             in_samples_nd,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_msg_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);
    localparam int SD = 1 << SAMPLE_BUF_LOG;
    localparam int MD = 1 << MSG_BUF_LOG;
    // Message FIFO holds at most MD-1 words (full when wp+1 == rp).
    localparam logic [MSG_BUF_LOG:0] M_FULL_OCC = (MSG_BUF_LOG+1)'(MD - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MSG  = 1'b1;

    logic [WIDTH-1:0]            r_s_mem [SD];
    logic [SAMPLE_BUF_LOG:0]     r_s_wp, r_s_rp;
    logic [WIDTH-1:0]            r_m_mem [MD];
    logic [MSG_BUF_LOG:0]        r_m_wp, r_m_cp, r_m_rp;
    logic [MSG_LENGTH_WIDTH-1:0] r_rem, r_cnt;
    logic                        r_discard;
    logic [0:0]                  r_state;

    logic                        w_s_empty, w_s_full, w_s_wr, w_s_err, w_s_rd;
    logic                        w_m_hdr, w_m_full, w_m_wr, w_m_err, w_m_ndisc;
    logic [MSG_LENGTH_WIDTH-1:0] w_m_len, w_m_nrem, w_head_len;
    logic [MSG_BUF_LOG:0]        w_m_base, w_m_nwp, w_m_ncp;
    logic                        w_m_avail, w_m_rd;
    logic [WIDTH-1:0]            w_m_head, w_s_head;

    // Sample FIFO: extra wrap bit distinguishes full from empty.
    assign w_s_empty = (r_s_wp == r_s_rp);
    assign w_s_full  = (r_s_wp[SAMPLE_BUF_LOG] != r_s_rp[SAMPLE_BUF_LOG]) &&
                       (r_s_wp[SAMPLE_BUF_LOG-1:0] == r_s_rp[SAMPLE_BUF_LOG-1:0]);
    assign w_s_wr    = in_samples_nd && !in_samples[WIDTH-1] && !w_s_full;
    assign w_s_err   = in_samples_nd && (in_samples[WIDTH-1] || w_s_full);
    assign w_s_head  = r_s_mem[r_s_rp[SAMPLE_BUF_LOG-1:0]];

    // Message input parser.
    always_comb begin
        w_m_hdr   = in_msg[WIDTH-1];
        w_m_len   = in_msg[WIDTH-2 -: MSG_LENGTH_WIDTH];
        // A header arriving mid-message restarts from the last commit point.
        // In DISCARD wp already equals cp, so the plain wp base is correct there.
        w_m_base  = (w_m_hdr && r_rem != '0) ? r_m_cp : r_m_wp;
        w_m_full  = ((w_m_base - r_m_rp) == M_FULL_OCC);
        w_m_wr    = 1'b0;
        w_m_err   = 1'b0;
        w_m_nwp   = r_m_wp;
        w_m_ncp   = r_m_cp;
        w_m_nrem  = r_rem;
        w_m_ndisc = r_discard;
        if (in_msg_nd) begin
            if (w_m_hdr) begin
                w_m_err = (r_rem != '0);
                if (w_m_full) begin
                    w_m_nwp   = r_m_cp;
                    w_m_err   = 1'b1;
                    w_m_ndisc = 1'b1;
                    w_m_nrem  = '0;
                end else begin
                    w_m_wr    = 1'b1;
                    w_m_nwp   = w_m_base + 1'b1;
                    w_m_nrem  = w_m_len;
                    w_m_ndisc = 1'b0;
                    if (w_m_len == '0) w_m_ncp = w_m_base + 1'b1;
                end
            end else if (!r_discard) begin
                if (r_rem == '0) begin
                    w_m_err = 1'b1;
                end else if (w_m_full) begin
                    // Message cannot fit: roll back and drop the rest of it.
                    w_m_nwp   = r_m_cp;
                    w_m_err   = 1'b1;
                    w_m_ndisc = 1'b1;
                    w_m_nrem  = '0;
                end else begin
                    w_m_wr   = 1'b1;
                    w_m_nwp  = r_m_wp + 1'b1;
                    w_m_nrem = r_rem - 1'b1;
                    if (r_rem == MSG_LENGTH_WIDTH'(1)) w_m_ncp = r_m_wp + 1'b1;
                end
            end
        end
    end

    // Output side: committed messages beat buffered samples; a message in
    // flight is never interrupted, its words are guaranteed present.
    assign w_m_avail  = (r_m_rp != r_m_cp);
    assign w_m_head   = r_m_mem[r_m_rp[MSG_BUF_LOG-1:0]];
    assign w_head_len = w_m_head[WIDTH-2 -: MSG_LENGTH_WIDTH];
    assign w_m_rd     = (r_state == ST_MSG) || w_m_avail;
    assign w_s_rd     = (r_state == ST_IDLE) && !w_m_avail && !w_s_empty;

    // Storage arrays carry no reset; pointers define their valid contents.
    always_ff @(posedge clk) begin
        if (w_s_wr) r_s_mem[r_s_wp[SAMPLE_BUF_LOG-1:0]] <= in_samples;
        if (w_m_wr) r_m_mem[w_m_base[MSG_BUF_LOG-1:0]]  <= in_msg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_wp    <= '0;
            r_s_rp    <= '0;
            r_m_wp    <= '0;
            r_m_cp    <= '0;
            r_m_rp    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_state   <= ST_IDLE;
            out_data  <= '0;
            out_nd    <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (w_s_wr) r_s_wp <= r_s_wp + 1'b1;
            if (w_s_rd) r_s_rp <= r_s_rp + 1'b1;
            r_m_wp    <= w_m_nwp;
            r_m_cp    <= w_m_ncp;
            r_rem     <= w_m_nrem;
            r_discard <= w_m_ndisc;
            if (w_s_err || w_m_err) error <= 1'b1;

            out_nd <= w_m_rd || w_s_rd;
            if (w_m_rd) begin
                out_data <= w_m_head;
                r_m_rp   <= r_m_rp + 1'b1;
            end else if (w_s_rd) begin
                out_data <= w_s_head;
            end

            if (r_state == ST_IDLE) begin
                if (w_m_avail) begin
                    r_cnt <= w_head_len;
                    if (w_head_len != '0) r_state <= ST_MSG;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == MSG_LENGTH_WIDTH'(1)) r_state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sample_msg_combiner.sv
// tb_sample_msg_combiner
//   Drives directed scenarios and randomized traffic into sample_msg_combiner
//   and compares every cycle against a queue-based reference model.
module tb_sample_msg_combiner;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_samples, in_msg, out_data;
    logic        in_samples_nd, in_msg_nd, out_nd, error;

    sample_msg_combiner #(
        .WIDTH(32), .SAMPLE_BUF_LOG(4), .MSG_BUF_LOG(6), .MSG_LENGTH_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_samples(in_samples), .in_samples_nd(in_samples_nd),
        .in_msg(in_msg), .in_msg_nd(in_msg_nd),
        .out_data(out_data), .out_nd(out_nd), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_out;
    logic        obs_nd;
    logic [31:0] obs_data;

    // Reference model state
    logic [31:0] sq[$];    // buffered samples
    logic [31:0] cq[$];    // committed, not yet emitted message words
    logic [31:0] pend[$];  // message being received
    logic [31:0] mq[$];    // random message stimulus backlog
    int rem, m_left;
    bit disc, m_err;

    function automatic int hdr_len(logic [31:0] w);
        return int'(w[30:15]);
    endfunction

    function automatic logic [31:0] mk_hdr(int len);
        return 32'h8000_0000 | (32'(len) << 15);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq.delete(); cq.delete(); pend.delete();
        rem = 0; m_left = 0; disc = 0; m_err = 0;
    endtask

    task automatic commit();
        foreach (pend[i]) cq.push_back(pend[i]);
        pend.delete();
    endtask

    task automatic overflow();
        m_err = 1; disc = 1; rem = 0; pend.delete();
    endtask

    // One clock of the model: output choice uses the state before this
    // cycle's inputs; capacity checks likewise use the pre-cycle fill.
    task automatic model_step(output bit e_nd, output logic [31:0] e_data);
        int cq_pre, sq_pre;
        cq_pre = cq.size();
        sq_pre = sq.size();
        e_nd = 0;
        e_data = '0;
        if (m_left > 0) begin
            e_data = cq.pop_front(); e_nd = 1; m_left--;
        end else if (cq.size() > 0) begin
            e_data = cq.pop_front(); e_nd = 1; m_left = hdr_len(e_data);
        end else if (sq.size() > 0) begin
            e_data = sq.pop_front(); e_nd = 1;
        end
        if (in_samples_nd) begin
            if (in_samples[31] || sq_pre == 16) m_err = 1;
            else sq.push_back(in_samples);
        end
        if (in_msg_nd) begin
            if (in_msg[31]) begin
                if (rem > 0) begin
                    m_err = 1; pend.delete();
                end
                if (cq_pre + pend.size() == 63) overflow();
                else begin
                    pend.push_back(in_msg);
                    rem = hdr_len(in_msg);
                    disc = 0;
                    if (rem == 0) commit();
                end
            end else if (!disc) begin
                if (rem == 0) m_err = 1;
                else if (cq_pre + pend.size() == 63) overflow();
                else begin
                    pend.push_back(in_msg);
                    rem--;
                    if (rem == 0) commit();
                end
            end
        end
    endtask

    task automatic step(bit snd, logic [31:0] s, bit mnd, logic [31:0] m);
        bit          e_nd;
        logic [31:0] e_data;
        in_samples_nd = snd; in_samples = s;
        in_msg_nd = mnd;     in_msg = m;
        @(posedge clk);
        #1;
        model_step(e_nd, e_data);
        obs_nd = out_nd;
        obs_data = out_data;
        if (out_nd) n_out++;
        chk("out_nd", {31'b0, out_nd}, {31'b0, e_nd});
        if (e_nd) chk("out_data", out_data, e_data);
        chk("error", {31'b0, error}, {31'b0, m_err});
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_nd", {31'b0, out_nd}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_out = 0;
    endtask

    task automatic gen_msg();
        int r, len, n;
        r = $urandom_range(0, 99);
        if (r < 4) begin
            mq.push_back($urandom & 32'h7FFF_FFFF);
            return;
        end
        len = (r < 8) ? $urandom_range(55, 75) : $urandom_range(0, 10);
        n = (r >= 8 && r < 14 && len > 0) ? $urandom_range(0, len - 1) : len;
        mq.push_back(mk_hdr(len) | ($urandom & 32'h7FFF));
        for (int i = 0; i < n; i++) mq.push_back($urandom & 32'h7FFF_FFFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        in_samples = '0; in_samples_nd = 0; in_msg = '0; in_msg_nd = 0;
        model_reset();
        n_out = 0;
        @(negedge clk);
        do_reset();

        // Five consecutive samples; first emerges two cycles after its strobe.
        step(1, 32'h1, 0, '0);
        chk("t1_lat_early", {31'b0, obs_nd}, 32'd0);
        step(1, 32'h2, 0, '0);
        chk("t1_first", obs_data, 32'h1);
        for (int i = 3; i <= 5; i++) step(1, 32'(i), 0, '0);
        idle(6);
        chk("t1_count", 32'(n_out), 32'd5);

        // Length-3 message while samples stream every cycle.
        for (int i = 0; i < 20; i++) begin
            if (i == 2)           step(1, 32'h100 + 32'(i), 1, mk_hdr(3));
            else if (i inside {[3:5]}) step(1, 32'h100 + 32'(i), 1, 32'h0000_0A00 + 32'(i));
            else                  step(1, 32'h100 + 32'(i), 0, '0);
        end
        idle(10);
        chk("t2_noerr", {31'b0, error}, 32'd0);

        // Truncated message superseded by a length-0 header.
        do_reset();
        step(0, '0, 1, mk_hdr(2));
        step(0, '0, 1, 32'h0000_0055);
        step(0, '0, 1, mk_hdr(0) | 32'h7);
        idle(5);
        chk("t3_err", {31'b0, error}, 32'd1);
        chk("t3_count", 32'(n_out), 32'd1);

        // 17 samples during a 20-word message overflow the sample FIFO.
        do_reset();
        step(0, '0, 1, mk_hdr(19));
        for (int i = 0; i < 19; i++) step(0, '0, 1, 32'h0000_0B00 + 32'(i));
        for (int i = 0; i < 17; i++) step(1, 32'h0000_0C00 + 32'(i), 0, '0);
        idle(25);
        chk("t4_err", {31'b0, error}, 32'd1);
        chk("t4_count", 32'(n_out), 32'd36);

        // Oversized message is dropped, following message survives.
        do_reset();
        step(0, '0, 1, mk_hdr(70));
        for (int i = 0; i < 70; i++) step(0, '0, 1, 32'h0000_0D00 + 32'(i));
        step(0, '0, 1, mk_hdr(1));
        step(0, '0, 1, 32'h0000_0EEE);
        idle(6);
        chk("t5_err", {31'b0, error}, 32'd1);
        chk("t5_count", 32'(n_out), 32'd2);

        // Asynchronous reset in the middle of message output.
        do_reset();
        step(1, 32'h8000_0001, 0, '0);
        step(0, '0, 1, mk_hdr(5));
        for (int i = 0; i < 5; i++) step(0, '0, 1, 32'h0000_0F00 + 32'(i));
        idle(3);
        chk("t6_mid_nd", {31'b0, out_nd}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_nd", {31'b0, out_nd}, 32'd0);
        chk("t6_rst_err", {31'b0, error}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1, 32'h42, 0, '0);
        step(0, '0, 0, '0);
        chk("t6_after", obs_data, 32'h42);

        // Randomized traffic, with periodic resets to clear the sticky error.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            mq.delete();
            for (int c = 0; c < 600; c++) begin
                bit          snd, mnd;
                logic [31:0] s, m;
                snd = ($urandom_range(0, 99) < 35);
                s = $urandom & 32'h7FFF_FFFF;
                if ($urandom_range(0, 99) < 3) s[31] = 1'b1;
                if (mq.size() == 0) gen_msg();
                mnd = ($urandom_range(0, 99) < 50);
                m = '0;
                if (mnd) m = mq.pop_front();
                step(snd, s, mnd, m);
            end
            idle(120);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
